// File: rtl/usb_desc_streamer.sv
// usb_desc_streamer: builds USB device/qualifier/configuration descriptors on the fly and streams them over valid/ready.
// Optional string descriptors (LANGID + product "FPGA USB") are enabled by defining USB_DESC_STRINGS_EN.
module usb_desc_streamer #(
  parameter logic [15:0] VENDORID   = 16'h33AA,
  parameter logic [15:0] PRODUCTID  = 16'h0120,
  parameter logic [15:0] VERSIONBCD = 16'h0100,
  parameter bit          HSSUPPORT  = 1'b1,
  parameter bit          SELFPOWERED = 1'b0,
  parameter logic [7:0]  MAXPOWER   = 8'hFA,
  parameter int          N_IF       = 2,
  parameter logic [95:0] IF_CLASS   = 96'hFF0000_FF0000_0A0000_FF4201
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [7:0]  i_req_type,
  input  logic [7:0]  i_req_index,
  input  logic [15:0] i_req_len,
  input  logic        i_hs,
  input  logic        i_abort,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_last,
  input  logic        i_tx_ready,
  output logic        o_done,
  output logic        o_stall
);
  typedef enum logic [1:0] {IDLE, SEND, STALL, DONE} state_t;
  typedef enum logic [2:0] {K_DEV, K_CFG, K_OTH, K_QUAL, K_STR0, K_STR1} kind_t;

  localparam logic [15:0] CFG_LEN = 16'(9 + 23 * N_IF);
  localparam logic [63:0] PROD_STR = "FPGA USB";
`ifdef USB_DESC_STRINGS_EN
  localparam logic [7:0] IPROD = 8'h01;
`else
  localparam logic [7:0] IPROD = 8'h00;
`endif

  state_t      r_state, w_next;
  kind_t       r_kind, w_kind, w_sel_kind;
  logic        r_spd, w_spd_in, w_sel_spd, w_ok, w_acc, w_hs;
  logic [7:0]  r_off, r_data, w_sel_off, w_byte;
  logic [15:0] r_rem, w_len, w_rlen;

  // Every descriptor byte is a pure function of what is being sent, where, and at which speed.
  function automatic logic [7:0] desc_byte(input kind_t k, input logic [7:0] off, input logic spd);
    logic [7:0] rel, n, r, mlo, mhi, b;
    logic [95:0] sh;
    logic [63:0] ps;
    rel = off - 8'd9;
    n = rel / 8'd23;
    r = rel % 8'd23;
    sh = IF_CLASS >> (24 * n);
    ps = PROD_STR << (8 * (off[7:1] - 7'd1));
    mlo = spd ? 8'h00 : 8'h40;
    mhi = spd ? 8'h02 : 8'h00;
    b = 8'h00;
    case (k)
      K_DEV:
        case (off)
          8'd0: b = 8'h12;
          8'd1: b = 8'h01;
          8'd2: b = HSSUPPORT ? 8'h00 : 8'h10;
          8'd3: b = HSSUPPORT ? 8'h02 : 8'h01;
          8'd7: b = 8'h40;
          8'd8: b = VENDORID[7:0];
          8'd9: b = VENDORID[15:8];
          8'd10: b = PRODUCTID[7:0];
          8'd11: b = PRODUCTID[15:8];
          8'd12: b = VERSIONBCD[7:0];
          8'd13: b = VERSIONBCD[15:8];
          8'd15: b = IPROD;
          8'd17: b = 8'h01;
          default: b = 8'h00;
        endcase
      K_QUAL:
        case (off)
          8'd0: b = 8'h0A;
          8'd1: b = 8'h06;
          8'd3: b = 8'h02;
          8'd7: b = 8'h40;
          8'd8: b = 8'h01;
          default: b = 8'h00;
        endcase
      K_CFG, K_OTH:
        if (off < 8'd9)
          case (off)
            8'd0: b = 8'h09;
            8'd1: b = (k == K_OTH) ? 8'h07 : 8'h02;
            8'd2: b = CFG_LEN[7:0];
            8'd3: b = CFG_LEN[15:8];
            8'd4: b = 8'(N_IF);
            8'd5: b = 8'h01;
            8'd7: b = SELFPOWERED ? 8'hC0 : 8'h80;
            8'd8: b = MAXPOWER;
            default: b = 8'h00;
          endcase
        else
          case (r)
            8'd0: b = 8'h09;
            8'd1: b = 8'h04;
            8'd2: b = n;
            8'd4: b = 8'h02;
            8'd5: b = sh[23:16];
            8'd6: b = sh[15:8];
            8'd7: b = sh[7:0];
            8'd9, 8'd16: b = 8'h07;
            8'd10, 8'd17: b = 8'h05;
            8'd11: b = 8'h81 + n;
            8'd18: b = 8'h01 + n;
            8'd12, 8'd19: b = 8'h02;
            8'd13, 8'd20: b = mlo;
            8'd14, 8'd21: b = mhi;
            default: b = 8'h00;
          endcase
      K_STR0: b = (off == 8'd0 || off == 8'd3) ? 8'h04 : (off == 8'd1) ? 8'h03 : (off == 8'd2) ? 8'h09 : 8'h00;
      K_STR1: b = (off == 8'd0) ? 8'h12 : (off == 8'd1) ? 8'h03 : off[0] ? 8'h00 : ps[63:56];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_comb begin
    w_kind = K_DEV;
    w_ok = 1'b0;
    case (i_req_type)
      8'd1: begin w_kind = K_DEV; w_ok = (i_req_index == 8'd0); end
      8'd2: begin w_kind = K_CFG; w_ok = (i_req_index == 8'd0); end
      8'd6: begin w_kind = K_QUAL; w_ok = (i_req_index == 8'd0) && HSSUPPORT; end
      8'd7: begin w_kind = K_OTH; w_ok = (i_req_index == 8'd0) && HSSUPPORT; end
`ifdef USB_DESC_STRINGS_EN
      8'd3: begin w_kind = (i_req_index == 8'd0) ? K_STR0 : K_STR1; w_ok = (i_req_index <= 8'd1); end
`endif
      default: ;
    endcase
  end

  assign w_len = (w_kind == K_DEV || w_kind == K_STR1) ? 16'd18 :
                 (w_kind == K_QUAL) ? 16'd10 :
                 (w_kind == K_STR0) ? 16'd4 : CFG_LEN;
  assign w_rlen = (w_len < i_req_len) ? w_len : i_req_len;
  assign w_spd_in = (i_req_type == 8'd7) ? ~i_hs : i_hs;
  assign w_acc = (r_state == IDLE) && i_req_valid && !i_abort;
  assign w_hs = (r_state == SEND) && i_tx_ready;
  // On accept the first byte is prefetched so data is valid the very next cycle.
  assign w_sel_kind = (r_state == IDLE) ? w_kind : r_kind;
  assign w_sel_off = (r_state == IDLE) ? 8'd0 : r_off + 8'd1;
  assign w_sel_spd = (r_state == IDLE) ? w_spd_in : r_spd;
  assign w_byte = desc_byte(w_sel_kind, w_sel_off, w_sel_spd);

  always_comb begin
    w_next = r_state;
    if (i_abort)
      w_next = IDLE;
    else
      case (r_state)
        IDLE: if (w_acc) w_next = !w_ok ? STALL : (w_rlen == 16'd0) ? DONE : SEND;
        SEND: if (w_hs && r_rem == 16'd1) w_next = DONE;
        default: w_next = IDLE;
      endcase
  end

  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) r_state <= IDLE;
    else r_state <= w_next;

  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      r_kind <= K_DEV;
      r_spd <= 1'b0;
      r_off <= 8'd0;
      r_rem <= 16'd0;
      r_data <= 8'd0;
    end else if (w_acc) begin
      r_kind <= w_kind;
      r_spd <= w_spd_in;
      r_off <= 8'd0;
      r_rem <= w_rlen;
      r_data <= w_byte;
    end else if (w_hs && !i_abort) begin
      r_off <= r_off + 8'd1;
      r_rem <= r_rem - 16'd1;
      r_data <= w_byte;
    end

  assign o_req_ready = (r_state == IDLE);
  assign o_tx_valid = (r_state == SEND);
  assign o_tx_data = o_tx_valid ? r_data : 8'd0;
  assign o_tx_last = o_tx_valid && (r_rem == 16'd1);
  assign o_done = (r_state == DONE);
  assign o_stall = (r_state == STALL);
endmodule
